adc_capture_multi: RTL and testbench
====================================

ADC_CAPTURE_MULTI -- requirements
Module: adc_capture_multi

Interface
REQ-001 Parameter NUM_CH, default 2: number of ADC channels captured in lockstep.
REQ-002 Parameter DATA_W, default 10: ADC sample width per channel.
REQ-003 Parameter AVG_LOG2, default 0: frames average 2^AVG_LOG2 samples per channel; legal range 0..4.
REQ-004 Parameter FIFO_DEPTH, default 8: output frame FIFO depth; power of two, minimum 2.
REQ-005 clk  in  1  sampling clock; all logic is on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 enable  in  1  capture enable, synchronous.
REQ-008 fmt_signed  in  1  0 = offset-binary output; 1 = two's complement (MSB inverted). Static while enable=1.
REQ-009 adc_in  in  NUM_CH*DATA_W  raw ADC buses; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-010 adc_clk_out  out  NUM_CH  per-channel converter clock, equal to clk.
REQ-011 adc_oe_out  out  NUM_CH  per-channel output enable, all bits equal to registered enable.
REQ-012 m_data  out  NUM_CH*DATA_W  frame at FIFO head, same channel packing as adc_in.
REQ-013 m_valid  out  1  FIFO non-empty.
REQ-014 m_ready  in  1  consumer accepts the frame when m_valid && m_ready.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 overflow  out  1  sticky: a frame was dropped.
REQ-017 clr_overflow  in  1  synchronous clear for overflow.

Function
REQ-018 Each channel SHALL pass through two register stages (d1, d2) every cycle, regardless of state.
REQ-019 FSM states: IDLE, FILL, ACC.
  - IDLE -> FILL on enable=1.
  - FILL -> ACC after exactly one cycle.
  - Any state -> IDLE on enable=0.
REQ-020 Entering IDLE SHALL clear the sample counter and all accumulators; a partial average is discarded, never written.
REQ-021 In ACC, each cycle: add d2 of every channel into a (DATA_W+AVG_LOG2)-bit unsigned accumulator; increment the sample counter.
REQ-022 On the 2^AVG_LOG2-th sample: frame = accumulator >> AVG_LOG2 (truncating); push frame to FIFO; restart accumulation from zero in the same cycle.
REQ-023 AVG_LOG2=0: one frame per ACC cycle. Latency: adc_in sampled at the first edge with enable high appears as m_data/m_valid after the third edge.
REQ-024 When fmt_signed=1, invert the MSB of each channel value after averaging, before the push.
REQ-025 FIFO is first-word-fall-through. m_data SHALL be stable while m_valid && !m_ready.
REQ-026 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-027 A push refused due to full SHALL drop the whole frame (all channels) and set overflow.
REQ-028 If overflow set and clr_overflow coincide in one cycle, set wins.
REQ-029 FIFO contents SHALL persist across enable=0 and remain drainable; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-030 On rst_n low, asynchronously:
  - state = IDLE;
  - sync stages, accumulators, counter and FIFO pointers = 0;
  - m_valid = 0, m_data = 0, fifo_level = 0, overflow = 0, adc_oe_out = 0.
REQ-031 After release, the block remains in IDLE until enable is sampled high.

Structure
REQ-032 Shared package adc_pkg SHALL hold the FSM state typedef and the AVG_LOG2 range limit.
REQ-033 The FIFO SHALL be a separate sub-module, adc_frame_fifo, parameterised by width (NUM_CH*DATA_W) and depth.

Verification
REQ-034 NUM_CH=2, AVG_LOG2=0, m_ready=1, ch0 ramp 0,1,2,...: m_valid rises after the third edge; ch0 sequence 0,1,2,... with no gaps.
REQ-035 AVG_LOG2=2, ch0 = 100,101,102,103: single frame ch0=101 (406>>2); next frame begins at the fifth sample.
REQ-036 FIFO_DEPTH=8, m_ready=0, 12 frames pushed: fifo_level=8, overflow=1. Then m_ready=1: the first 8 frames emerge in order. Then clr_overflow: overflow=0.
REQ-037 fmt_signed=1: input 0x200 -> output 0x000; 0x000 -> 0x200; 0x3FF -> 0x1FF.
REQ-038 AVG_LOG2=2, enable dropped after 2 samples, then re-raised: no partial frame written; next frame averages only 4 fresh samples.
REQ-039 rst_n asserted mid-stream with FIFO holding 5 frames: m_valid, fifo_level, overflow and adc_oe_out go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel ADC capture block.
package adc_pkg;

  localparam int unsigned AVG_LOG2_MAX = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ACC  = 2'd2
  } adc_state_e;

endpackage

// File: rtl/adc_frame_fifo.sv
// First-word-fall-through frame FIFO with a registered head, valid, full and level.
module adc_frame_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [LW-1:0]    count;
  logic [LW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             full;
  logic             pop_c;
  logic             wr_c;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop_c      = m_valid && m_ready;
    wr_c       = push && (!full || pop_c);
    drop_c     = push && !wr_c;
    rd_ptr_nxt = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    count_nxt  = count + LW'(wr_c) - LW'(pop_c);
    head_nxt   = (wr_c && (wr_ptr == rd_ptr_nxt)) ? wdata : mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (wr_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_ptr_nxt;
      count   <= count_nxt;
      full    <= (count_nxt == LW'(DEPTH));
      m_valid <= (count_nxt != '0);
      m_data  <= head_nxt;
    end
  end

  assign level = count;

endmodule

// File: rtl/adc_capture_multi.sv
// Lockstep multi-channel ADC capture: two-stage input sync, block averaging,
// optional sign conversion and a frame FIFO toward the consumer.
module adc_capture_multi
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned AVG_LOG2   = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          fmt_signed,
  input  logic [NUM_CH*DATA_W-1:0]      adc_in,
  output logic [NUM_CH-1:0]             adc_clk_out,
  output logic [NUM_CH-1:0]             adc_oe_out,
  output logic [NUM_CH*DATA_W-1:0]      m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int unsigned W     = NUM_CH * DATA_W;
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  if (AVG_LOG2 > AVG_LOG2_MAX) begin : g_bad_avg
    $error("adc_capture_multi: AVG_LOG2 out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("adc_capture_multi: FIFO_DEPTH must be a power of two >= 2");
  end

  adc_state_e                          state;
  logic [NUM_CH-1:0][DATA_W-1:0]       d1;
  logic [NUM_CH-1:0][DATA_W-1:0]       d2;
  logic [NUM_CH-1:0][ACC_W-1:0]        acc;
  logic [NUM_CH-1:0][ACC_W-1:0]        sum_c;
  logic [NUM_CH-1:0][DATA_W-1:0]       avg_c;
  logic [W-1:0]                        frame_c;
  logic [CNT_W-1:0]                    cnt;
  logic                                last_c;
  logic                                push_c;
  logic                                drop_c;

  assign adc_clk_out = {NUM_CH{clk}};

  // Running sums and the outgoing frame for the sample currently in d2.
  always_comb begin
    sum_c   = '0;
    avg_c   = '0;
    frame_c = '0;
    last_c  = (cnt == CNT_W'((1 << AVG_LOG2) - 1));
    push_c  = (state == ST_ACC) && enable && last_c;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_c[c] = acc[c] + ACC_W'(d2[c]);
      avg_c[c] = DATA_W'(sum_c[c] >> AVG_LOG2);
      if (fmt_signed) avg_c[c][DATA_W-1] = ~avg_c[c][DATA_W-1];
      frame_c[c*DATA_W +: DATA_W] = avg_c[c];
    end
  end

  // Input synchroniser and output-enable run every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1         <= '0;
      d2         <= '0;
      adc_oe_out <= '0;
    end else begin
      d1         <= adc_in;
      d2         <= d1;
      adc_oe_out <= {NUM_CH{enable}};
    end
  end

  // Dropping enable always returns to IDLE and discards any partial average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FILL;
        ST_FILL: state <= ST_ACC;
        ST_ACC: begin
          if (last_c) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= sum_c;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop_c)       overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

  adc_frame_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .wdata   (frame_c),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .level   (fifo_level),
    .drop_c  (drop_c)
  );

endmodule

// File: tb/tb_adc_capture_multi.sv
// Directed bench for adc_capture_multi: one instance without averaging, one with 4-sample averaging.
module tb_adc_capture_multi;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned W      = NUM_CH * DATA_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             fmt_signed;
  logic [W-1:0]     adc_in;
  logic             m_ready;
  logic             clr_overflow;

  logic [NUM_CH-1:0] a_clk, a_oe, b_clk, b_oe;
  logic [W-1:0]      a_data, b_data;
  logic              a_valid, b_valid, a_ovf, b_ovf;
  logic [3:0]        a_level, b_level;

  int vectors    = 0;
  int miscompares = 0;

  int fmt_in0 [3] = '{32'h200, 32'h000, 32'h3FF};
  int fmt_in1 [3] = '{32'h3FF, 32'h200, 32'h000};
  int fmt_ex0 [3] = '{32'h000, 32'h200, 32'h1FF};
  int fmt_ex1 [3] = '{32'h1FF, 32'h000, 32'h200};
  int part_s  [12] = '{1000, 1000, 500, 500, 500, 500, 40, 41, 42, 43, 0, 0};

  always #5 clk = ~clk;

  adc_capture_multi #(.NUM_CH(2), .DATA_W(10), .AVG_LOG2(0), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fmt_signed(fmt_signed), .adc_in(adc_in),
    .adc_clk_out(a_clk), .adc_oe_out(a_oe), .m_data(a_data), .m_valid(a_valid),
    .m_ready(m_ready), .fifo_level(a_level), .overflow(a_ovf), .clr_overflow(clr_overflow)
  );

  adc_capture_multi #(.NUM_CH(2), .DATA_W(10), .AVG_LOG2(2), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fmt_signed(fmt_signed), .adc_in(adc_in),
    .adc_clk_out(b_clk), .adc_oe_out(b_oe), .m_data(b_data), .m_valid(b_valid),
    .m_ready(m_ready), .fifo_level(b_level), .overflow(b_ovf), .clr_overflow(clr_overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch(input logic [W-1:0] d, input int c);
    return 32'(d[c*DATA_W +: DATA_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int c0, input int c1);
    adc_in = {DATA_W'(c1), DATA_W'(c0)};
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    fmt_signed   = 1'b0;
    m_ready      = 1'b0;
    clr_overflow = 1'b0;
    adc_in       = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_level", 32'(a_level), 32'd0);
    check("rst_ovf",   32'(a_ovf),   32'd0);
    check("rst_oe",    32'(a_oe),    32'd0);
    check("rst_data",  32'(a_data),  32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("clk_out_hi", 32'(a_clk), 32'({clk, clk}));
    #5;
    check("clk_out_lo", 32'(a_clk), 32'({clk, clk}));

    // Ramp, no averaging: first frame after the third edge, then gap-free
    do_reset();
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_in(i - 1, 1023 - (i - 1));
      tick();
      if (i == 1) check("ramp_oe", 32'(a_oe), 32'd3);
      if (i < 3) begin
        check("ramp_valid_early", 32'(a_valid), 32'd0);
      end else begin
        check("ramp_valid", 32'(a_valid), 32'd1);
        check("ramp_ch0", ch(a_data, 0), 32'(i - 3));
        check("ramp_ch1", ch(a_data, 1), 32'(1023 - (i - 3)));
        check("ramp_level", 32'(a_level), 32'd1);
      end
    end

    // Four-sample averaging with truncation
    do_reset();
    m_ready = 1'b1;
    enable  = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      set_in(99 + i, 198 + 2 * i);
      tick();
      if (i == 6) begin
        check("avg1_valid", 32'(b_valid), 32'd1);
        check("avg1_ch0", ch(b_data, 0), 32'd101);
        check("avg1_ch1", ch(b_data, 1), 32'd203);
      end else if (i == 10) begin
        check("avg2_valid", 32'(b_valid), 32'd1);
        check("avg2_ch0", ch(b_data, 0), 32'd105);
        check("avg2_ch1", ch(b_data, 1), 32'd211);
      end else begin
        check("avg_valid_gap", 32'(b_valid), 32'd0);
      end
    end

    // Overflow: 12 frames into a depth-8 FIFO, then drain after enable drops
    do_reset();
    enable = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      set_in(10 + i, 0);
      tick();
    end
    check("ovf_level", 32'(a_level), 32'd8);
    check("ovf_flag",  32'(a_ovf),   32'd1);
    enable = 1'b0;
    tick();
    check("ovf_hold_level", 32'(a_level), 32'd8);
    check("ovf_head_stable", ch(a_data, 0), 32'd11);
    m_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check("drain_valid", 32'(a_valid), 32'd1);
      check("drain_ch0", ch(a_data, 0), 32'(11 + j));
      tick();
    end
    check("drain_empty", 32'(a_valid), 32'd0);
    check("drain_level", 32'(a_level), 32'd0);
    check("ovf_sticky",  32'(a_ovf),   32'd1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(a_ovf), 32'd0);

    // Two's complement output format
    do_reset();
    fmt_signed = 1'b1;
    m_ready    = 1'b1;
    enable     = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 3) set_in(fmt_in0[i-1], fmt_in1[i-1]);
      tick();
      if (i >= 3) begin
        check("fmt_ch0", ch(a_data, 0), 32'(fmt_ex0[i-3]));
        check("fmt_ch1", ch(a_data, 1), 32'(fmt_ex1[i-3]));
      end
    end

    // Partial average discarded when enable drops mid-block
    do_reset();
    m_ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      enable = (k < 5 || k > 6);
      set_in(part_s[k-1], 0);
      tick();
      if (k < 12) check("part_no_frame", 32'(b_valid), 32'd0);
      else begin
        check("part_valid", 32'(b_valid), 32'd1);
        check("part_ch0", ch(b_data, 0), 32'd41);
      end
    end

    // Asynchronous reset with frames queued
    do_reset();
    enable = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      set_in(i, i);
      tick();
    end
    check("pre_rst_level", 32'(a_level), 32'd5);
    check("pre_rst_valid", 32'(a_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_valid), 32'd0);
    check("arst_level", 32'(a_level), 32'd0);
    check("arst_ovf",   32'(a_ovf),   32'd0);
    check("arst_oe",    32'(a_oe),    32'd0);
    tick();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
